// File: rtl/simon_pkg.sv
// Shared constants and elaboration helpers for the parametrised Simon encrypt engine.
package simon_pkg;

  // z sequences stored with z[i] at bit i
  localparam logic [61:0] SIMON_Z0 = 62'b01100111000011010100100010111110110011100001101010010001011111;
  localparam logic [61:0] SIMON_Z1 = 62'b01011010000110010011111011100010101101000011001001111101110001;
  localparam logic [61:0] SIMON_Z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;
  localparam logic [61:0] SIMON_Z3 = 62'b11110000101100111001010001001000000111101001100011010111011011;
  localparam logic [61:0] SIMON_Z4 = 62'b11110111001001010011000011101000000100011011010110011110001011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } simon_state_e;

  function automatic bit simon_legal(input int n, input int m);
    return (n == 16 && m == 4) ||
           (n == 24 && (m == 3 || m == 4)) ||
           (n == 32 && (m == 3 || m == 4)) ||
           (n == 48 && (m == 2 || m == 3)) ||
           (n == 64 && (m >= 2 && m <= 4));
  endfunction

  function automatic int simon_rounds(input int n, input int m);
    if (n == 16 && m == 4) return 32;
    if (n == 24)           return 36;
    if (n == 32)           return (m == 3) ? 42 : 44;
    if (n == 48)           return (m == 2) ? 52 : 54;
    if (n == 64)           return (m == 2) ? 68 : ((m == 3) ? 69 : 72);
    return 0;
  endfunction

  function automatic int simon_zsel(input int n, input int m);
    if ((n == 16 && m == 4) || (n == 24 && m == 3)) return 0;
    if (n == 24 && m == 4)                          return 1;
    if ((n == 32 && m == 3) || (n == 48 && m == 2) || (n == 64 && m == 2)) return 2;
    if ((n == 32 && m == 4) || (n == 48 && m == 3) || (n == 64 && m == 3)) return 3;
    return 4;
  endfunction

  function automatic logic [61:0] simon_zseq(input int n, input int m);
    case (simon_zsel(n, m))
      0:       return SIMON_Z0;
      1:       return SIMON_Z1;
      2:       return SIMON_Z2;
      3:       return SIMON_Z3;
      default: return SIMON_Z4;
    endcase
  endfunction

endpackage

// File: rtl/simon_round_step.sv
// One Simon round plus one key-schedule step; the key window's oldest word (LSBs) is the round key.
module simon_round_step
  import simon_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  input  logic [N*M-1:0] key_win,
  input  logic           z_bit,
  output logic [N-1:0]   x_nx,
  output logic [N-1:0]   y_nx,
  output logic [N*M-1:0] key_win_nx
);

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int r);
    return (v << r) | (v >> (N - r));
  endfunction

  logic [N-1:0] k_old;
  logic [N-1:0] k_top;
  logic [N-1:0] t_rot;
  logic [N-1:0] t_mix;
  logic [N-1:0] k_new;

  always_comb begin
    k_old = key_win[N-1:0];
    k_top = key_win[N*M-1 -: N];
    t_rot = rol(k_top, N - 3);
    if (M == 4) t_rot = t_rot ^ key_win[2*N-1:N];
    t_mix = t_rot ^ rol(t_rot, N - 1);
    k_new = ~k_old ^ t_mix ^ {{(N-1){1'b0}}, z_bit} ^ N'(3);

    x_nx       = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k_old;
    y_nx       = x;
    key_win_nx = {k_new, key_win[N*M-1:N]};
  end

endmodule

// File: rtl/simon_iter_enc.sv
// Iterative Simon encrypt engine: one round per clock, on-the-fly key expansion, valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for a block; in_rdy high
//   RUN   | one round + key step per cycle until T rounds are done
//   DONE  | ciphertext presented with out_vld; may accept the next block on handshake
module simon_iter_enc
  import simon_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2*N-1:0] in_data,
  input  logic [N*M-1:0] in_key,
  input  logic           in_key_load,
  input  logic           in_vld,
  output logic           in_rdy,
  output logic [2*N-1:0] out_data,
  output logic           out_vld,
  input  logic           out_rdy
);

  if (!simon_legal(N, M)) begin : g_illegal
    $error("simon_iter_enc: illegal (N,M) pair");
  end

  localparam int          T         = simon_rounds(N, M);
  localparam logic [6:0]  RCNT_LAST = 7'(T - 1);
  localparam logic [61:0] Z_SEQ     = simon_zseq(N, M);

  simon_state_e   state_q, state_d;
  logic [N-1:0]   x_q, x_d, y_q, y_d;
  logic [N*M-1:0] kwin_q, kwin_d;
  logic [N*M-1:0] key_q, key_d;
  logic [6:0]     rcnt_q, rcnt_d;
  logic [5:0]     zidx_q, zidx_d;

  logic [N-1:0]   x_nx, y_nx;
  logic [N*M-1:0] kwin_nx;
  logic           accept;

  simon_round_step #(.N(N), .M(M)) u_step (
    .x          (x_q),
    .y          (y_q),
    .key_win    (kwin_q),
    .z_bit      (Z_SEQ[zidx_q]),
    .x_nx       (x_nx),
    .y_nx       (y_nx),
    .key_win_nx (kwin_nx)
  );

  // Handshake outputs are forced low while reset is held.
  assign in_rdy   = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_rdy));
  assign out_vld  = rst_n & (state_q == ST_DONE);
  assign out_data = {x_q, y_q};
  assign accept   = in_vld & in_rdy;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    kwin_d  = kwin_q;
    key_d   = key_q;
    rcnt_d  = rcnt_q;
    zidx_d  = zidx_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          x_d     = in_data[2*N-1:N];
          y_d     = in_data[N-1:0];
          kwin_d  = in_key_load ? in_key : key_q;
          if (in_key_load) key_d = in_key;
          rcnt_d  = 7'd0;
          zidx_d  = 6'd0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE && out_rdy) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        x_d    = x_nx;
        y_d    = y_nx;
        kwin_d = kwin_nx;
        rcnt_d = rcnt_q + 7'd1;
        zidx_d = (zidx_q == 6'd61) ? 6'd0 : zidx_q + 6'd1;
        if (rcnt_q == RCNT_LAST) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      kwin_q  <= '0;
      key_q   <= '0;
      rcnt_q  <= '0;
      zidx_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      kwin_q  <= kwin_d;
      key_q   <= key_d;
      rcnt_q  <= rcnt_d;
      zidx_q  <= zidx_d;
    end
  end

endmodule

// File: tb/tb_simon_iter_enc.sv
// Self-checking bench: known-answer vectors on three instances plus backpressure, reset and streaming sequences.
module tb_simon_iter_enc;

  localparam int BUDGET = 200;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_vld, in_kl, out_rdy;
  wire  [2:0]  in_rdy, out_vld;
  logic [31:0] d16;
  wire  [31:0] q16;
  logic [63:0] k16;
  logic [63:0] d32;
  wire  [63:0] q32;
  logic [127:0] k32, d64, k64;
  wire  [127:0] q64;

  int n_cmp = 0;
  int n_err = 0;

  simon_iter_enc #(.N(16), .M(4)) u_enc16 (
    .clk(clk), .rst_n(rst_n), .in_data(d16), .in_key(k16), .in_key_load(in_kl[0]),
    .in_vld(in_vld[0]), .in_rdy(in_rdy[0]), .out_data(q16), .out_vld(out_vld[0]), .out_rdy(out_rdy[0]));

  simon_iter_enc #(.N(32), .M(4)) u_enc32 (
    .clk(clk), .rst_n(rst_n), .in_data(d32), .in_key(k32), .in_key_load(in_kl[1]),
    .in_vld(in_vld[1]), .in_rdy(in_rdy[1]), .out_data(q32), .out_vld(out_vld[1]), .out_rdy(out_rdy[1]));

  simon_iter_enc #(.N(64), .M(2)) u_enc64 (
    .clk(clk), .rst_n(rst_n), .in_data(d64), .in_key(k64), .in_key_load(in_kl[2]),
    .in_vld(in_vld[2]), .in_rdy(in_rdy[2]), .out_data(q64), .out_vld(out_vld[2]), .out_rdy(out_rdy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Independent Simon32/64 reference: full key expansion up front, z0 in published bit order.
  localparam logic [61:0] ZP0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  function automatic logic [15:0] rl16(input logic [15:0] v, input int r);
    return (v << r) | (v >> (16 - r));
  endfunction

  function automatic logic [31:0] model16(input logic [63:0] key, input logic [31:0] pt);
    logic [15:0] k[32];
    logic [15:0] x, y, t;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rl16(k[i-1], 13) ^ k[i-3];
      t = t ^ rl16(t, 15);
      k[i] = ~k[i-4] ^ t ^ {15'b0, ZP0[61-(i-4)]} ^ 16'd3;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (rl16(x, 1) & rl16(x, 8)) ^ rl16(x, 2) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int j, input logic kl, input logic [127:0] pt, input logic [255:0] key);
    in_kl[j] = kl;
    case (j)
      0: begin d16 = pt[31:0]; k16 = key[63:0];  end
      1: begin d32 = pt[63:0]; k32 = key[127:0]; end
      default: begin d64 = pt; k64 = key[127:0]; end
    endcase
  endtask

  function automatic logic [127:0] get_q(input int j);
    case (j)
      0: return {96'b0, q16};
      1: return {64'b0, q32};
      default: return q64;
    endcase
  endfunction

  // Present a block and wait (bounded) for its accept edge; returns at #1 after that edge.
  task automatic do_accept(input int j, input logic kl, input logic [127:0] pt, input logic [255:0] key,
                           input bit drop, output int wt);
    set_in(j, kl, pt, key);
    in_vld[j] = 1'b1;
    wt = 0;
    @(negedge clk);
    while (!in_rdy[j] && wt < BUDGET) begin
      @(negedge clk);
      wt++;
    end
    if (!in_rdy[j]) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: inst %0d in_rdy still 0 after %0d cycles", j, wt);
    end
    @(posedge clk);
    #1;
    if (drop) in_vld[j] = 1'b0;
  endtask

  // Counts edges after the accept edge until out_vld is seen (bounded).
  task automatic wait_out(input int j, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_vld[j] && lat < BUDGET);
  endtask

  typedef struct {
    int           inst;
    logic         kl;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  localparam logic [63:0]  KEY16 = 64'h1918_1110_0908_0100;
  localparam logic [31:0]  PT16  = 32'h6565_6877;
  localparam logic [31:0]  CT16  = 32'hc69b_e9bb;
  localparam logic [127:0] KEY32 = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  PT32  = 64'h656b696c_20646e75;
  localparam logic [63:0]  CT32  = 64'h44c8fc20_b9dfa07a;
  localparam logic [127:0] KEY64 = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT64  = 128'h6373656420737265_6c6c657661727420;
  localparam logic [127:0] CT64  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
  localparam logic [63:0]  KEYX  = 64'h0123_4567_89ab_cdef;

  vec_t vt[7];
  logic [31:0] bb_pt[5];
  logic [63:0] bb_key[5];
  logic        bb_kl[5];
  logic [31:0] bb_exp[5];

  initial begin
    int wt, lat, seen;
    logic [31:0] held;
    logic [63:0] eff;

    rst_n = 1'b0;
    in_vld = '0; in_kl = '0; out_rdy = 3'b111;
    d16 = '0; k16 = '0; d32 = '0; k32 = '0; d64 = '0; k64 = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy_low", 128'(in_rdy), 128'(3'b000));
    chk("rst_out_vld_low", 128'(out_vld), 128'(3'b000));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_rdy", 128'(in_rdy), 128'(3'b111));
    chk("post_rst_out_data", {q64 | 128'(q32) | 128'(q16)}, 128'b0);

    vt[0] = '{0, 1'b1, 256'(KEY16), 128'(PT16), 128'(CT16), 32};
    vt[1] = '{1, 1'b1, 256'(KEY32), 128'(PT32), 128'(CT32), 44};
    vt[2] = '{2, 1'b1, 256'(KEY64), PT64,        CT64,        68};
    vt[3] = '{0, 1'b0, 256'h5a5a_a5a5_dead_beef, 128'(PT16), 128'(CT16), 32};
    vt[4] = '{2, 1'b0, 256'h1234_5678_9abc_def0, PT64, CT64, 68};
    vt[5] = '{0, 1'b1, 256'(KEYX), 128'h0000_0000_dead_beef, 128'(model16(KEYX, 32'hdead_beef)), 32};
    vt[6] = '{0, 1'b0, 256'hffff_ffff_ffff_ffff, 128'h0, 128'(model16(KEYX, 32'h0)), 32};

    foreach (vt[v]) begin
      out_rdy = 3'b111;
      do_accept(vt[v].inst, vt[v].kl, vt[v].pt, vt[v].key, 1'b1, wt);
      wait_out(vt[v].inst, lat);
      chk($sformatf("vec%0d_latency", v), 128'(lat), 128'(vt[v].lat));
      chk($sformatf("vec%0d_ct", v), get_q(vt[v].inst), vt[v].ct);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_vld_clear", v), 128'(out_vld[vt[v].inst]), 128'b0);
    end

    // Backpressure: result must hold for 20 cycles, then a reuse-key accept straight from DONE.
    out_rdy[0] = 1'b0;
    do_accept(0, 1'b1, 128'(PT16), 256'(KEY16), 1'b1, wt);
    wait_out(0, lat);
    chk("bp_latency", 128'(lat), 128'd32);
    chk("bp_ct", 128'(q16), 128'(CT16));
    held = q16;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {95'b0, out_vld[0], in_rdy[0], q16}, {95'b0, 1'b1, 1'b0, CT16});
    end
    out_rdy[0] = 1'b1;
    do_accept(0, 1'b0, 128'(PT16), 256'h0bad_0bad_0bad_0bad, 1'b1, wt);
    chk("bp_no_idle_cycle", 128'(wt), 128'd0);
    wait_out(0, lat);
    chk("bp_second_latency", 128'(lat), 128'd32);
    chk("bp_second_ct", 128'(q16), 128'(held));
    @(posedge clk);
    #1;

    // Reset during RUN after round 10: block abandoned, stored key cleared.
    do_accept(0, 1'b1, 128'(PT16), 256'(KEY16), 1'b1, wt);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    chk("midrun_rst_in_rdy", 128'(in_rdy[0]), 128'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_vld[0]) seen = 1;
    end
    chk("midrun_rst_no_out_vld", 128'(seen), 128'd0);
    chk("midrun_rst_idle", 128'(in_rdy[0]), 128'd1);
    do_accept(0, 1'b0, 128'(PT16), 256'(KEY16), 1'b1, wt);
    wait_out(0, lat);
    chk("zero_key_latency", 128'(lat), 128'd32);
    chk("zero_key_ct", 128'(q16), 128'(model16(64'h0, PT16)));
    @(posedge clk);
    #1;

    // Streaming: in_vld held high, alternating keys, one reuse-key block accepted from DONE.
    bb_pt  = '{32'h0000_0001, 32'h8000_0000, 32'h1357_9bdf, 32'hfedc_ba98, 32'h6565_6877};
    bb_key = '{KEY16, KEYX, KEY16, 64'hffff_0000_ffff_0000, KEYX};
    bb_kl  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    eff = 64'h0;
    foreach (bb_pt[b]) begin
      if (bb_kl[b]) eff = bb_key[b];
      bb_exp[b] = model16(eff, bb_pt[b]);
    end
    do_accept(0, bb_kl[0], 128'(bb_pt[0]), 256'(bb_key[0]), 1'b0, wt);
    set_in(0, bb_kl[1], 128'(bb_pt[1]), 256'(bb_key[1]));
    for (int b = 0; b < 5; b++) begin
      wait_out(0, lat);
      chk($sformatf("b2b%0d_latency", b), 128'(lat), 128'd32);
      chk($sformatf("b2b%0d_ct", b), 128'(q16), 128'(bb_exp[b]));
      @(posedge clk);
      #1;
      if (b < 4) begin
        // next block taken on the DONE handshake edge: accepts are T rounds plus one cycle apart
        chk($sformatf("b2b%0d_next_accepted", b), 128'({in_rdy[0], out_vld[0]}), 128'b0);
        if (b + 2 < 5) set_in(0, bb_kl[b+2], 128'(bb_pt[b+2]), 256'(bb_key[b+2]));
        else in_vld[0] = 1'b0;
      end else begin
        chk("b2b_final_idle", 128'({in_rdy[0], out_vld[0]}), 128'(2'b10));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
